// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero register,
// registered reads, write-to-read bypass and a sequential bulk-clear sweep.
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_EN  = 1,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*WIDTH-1:0]  rd_data,
  input  logic                       clear_req,
  output logic                       busy,
  output logic                       wr_drop,
  output logic                       dbg_state
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_C  = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH-1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                wr_accept;
  logic                clr_we;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_EN != 0) && (a == ZERO_C);
  endfunction

  // Handshake: there is no ready; a write request is either accepted on the
  // edge, silently ignored (out of range / zero register), or rejected with
  // wr_drop=1 when a clear sweep is running.
  assign clr_we    = (state_q == CLEAR);
  assign busy      = clr_we;
  assign wr_drop   = wr_en & busy;
  assign dbg_state = state_q;
  assign wr_accept = wr_en & ~busy & in_range(wr_addr) & ~is_zero_reg(wr_addr);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr_q == LAST_C) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep and host writes never collide: host writes are refused while busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (clr_we) mem_q[ptr_q] <= '0;
      if (wr_accept) mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [WIDTH-1:0]  rd_d;
    logic [WIDTH-1:0]  rd_q;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Priority: range, zero register, register being cleared, bypass, storage.
    always_comb begin
      rd_d = '0;
      if (!in_range(ra) || is_zero_reg(ra)) begin
        rd_d = '0;
      end else if (clr_we && (ra == ptr_q)) begin
        rd_d = '0;
      end else if ((BYPASS != 0) && wr_accept && (wr_addr == ra)) begin
        rd_d = wr_data;
      end else begin
        rd_d = mem_q[ra];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_d;
    end

    assign rd_data[k*WIDTH +: WIDTH] = rd_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a BYPASS=0/ZERO_EN=0
// build sharing the same stimulus.
module tb_regfile_mp;

  logic         clk;
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [9:0]   rd_addr;
  logic         clear_req;
  logic [127:0] rd_data,  alt_rd_data;
  logic         busy,     alt_busy;
  logic         wr_drop,  alt_wr_drop;
  logic         dbg_state, alt_dbg_state;

  int tests  = 0;
  int failed = 0;

  regfile_mp u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .clear_req(clear_req), .busy(busy), .wr_drop(wr_drop), .dbg_state(dbg_state)
  );

  regfile_mp #(.ZERO_EN(0), .BYPASS(0)) u_alt (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(alt_rd_data),
    .clear_req(clear_req), .busy(alt_busy), .wr_drop(alt_wr_drop),
    .dbg_state(alt_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [63:0] e0;
    logic [63:0] e1;
    logic [63:0] a0;
    logic [63:0] a1;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {ra1, ra0};
  endtask

  initial begin
    int cyc;
    reset     = 1'b0;
    clear_req = 1'b0;
    drive(1'b1, 5'd0, 64'h0, 5'd0, 5'd0);

    vecs[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0123_4567, 5'd0,  5'd0,  64'h0, 64'h0, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 5'd0,  64'h0, 5'd5,  5'd5,  64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567,
                64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567};
    vecs[2] = '{1'b1, 5'd7,  64'hA5, 5'd7,  5'd5,  64'hA5, 64'hDEAD_BEEF_0123_4567,
                64'h0, 64'hDEAD_BEEF_0123_4567};
    vecs[3] = '{1'b0, 5'd0,  64'h0, 5'd7,  5'd7,  64'hA5, 64'hA5, 64'hA5, 64'hA5};
    vecs[4] = '{1'b1, 5'd31, 64'hFF, 5'd31, 5'd5, 64'h0, 64'hDEAD_BEEF_0123_4567,
                64'h0, 64'hDEAD_BEEF_0123_4567};
    vecs[5] = '{1'b0, 5'd0,  64'h0, 5'd31, 5'd7,  64'h0, 64'hA5, 64'hFF, 64'hA5};
    vecs[6] = '{1'b1, 5'd7,  64'h1234, 5'd7, 5'd7, 64'h1234, 64'h1234, 64'hA5, 64'hA5};
    vecs[7] = '{1'b0, 5'd0,  64'h0, 5'd7,  5'd5,  64'h1234, 64'hDEAD_BEEF_0123_4567,
                64'h1234, 64'hDEAD_BEEF_0123_4567};

    // Reset state, checked while reset is held low.
    repeat (3) @(negedge clk);
    check("rst_rd0", rd_data[63:0], 64'h0);
    check("rst_rd1", rd_data[127:64], 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_wr_drop", {63'h0, wr_drop}, 64'h0);
    check("rst_alt_rd0", alt_rd_data[63:0], 64'h0);
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    @(negedge clk);
    check("post_rst_rd0", rd_data[63:0], 64'h0);
    check("post_rst_busy", {63'h0, busy}, 64'h0);

    // Table-driven write/read/bypass/zero-register vectors.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
      #1 check($sformatf("vec%0d_wr_drop", i), {63'h0, wr_drop}, 64'h0);
      @(negedge clk);
      check($sformatf("vec%0d_rd0", i), rd_data[63:0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), rd_data[127:64], vecs[i].e1);
      check($sformatf("vec%0d_alt_rd0", i), alt_rd_data[63:0], vecs[i].a0);
      check($sformatf("vec%0d_alt_rd1", i), alt_rd_data[127:64], vecs[i].a1);
    end

    // Fill every register with its index.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), 64'(i), 5'd0, 5'd0);
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);

    // Single-cycle clear pulse: exact sweep length, mid-sweep reads, dropped write.
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("sweep_state", {63'h0, dbg_state}, 64'h1);
    cyc = 0;
    while (busy && cyc < 100) begin
      if (cyc == 3) begin
        check("sweep_rd_reg0", rd_data[63:0], 64'h0);
        check("sweep_rd_reg30", rd_data[127:64], 64'd30);
      end
      if (cyc == 31) begin
        check("sweep_clr_bypass_reg30", rd_data[63:0], 64'h0);
        check("sweep_rd_reg31", rd_data[127:64], 64'h0);
        check("sweep_alt_rd_reg31", alt_rd_data[127:64], 64'd31);
      end
      if (cyc == 2) begin
        drive(1'b1, 5'd30, 64'hBAD, 5'd0, 5'd30);
        #1 check("sweep_wr_drop", {63'h0, wr_drop}, 64'h1);
      end else if (cyc == 30) begin
        drive(1'b0, 5'd0, 64'h0, 5'd30, 5'd31);
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("sweep_len", 64'(cyc), 64'd32);
    check("sweep_done_busy", {63'h0, busy}, 64'h0);

    // Every register must now read zero in both builds.
    for (int i = 0; i < 32; i += 2) begin
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(i + 1));
      @(negedge clk);
      check($sformatf("post_sweep_r%0d", i), rd_data[63:0], 64'h0);
      check($sformatf("post_sweep_r%0d", i + 1), rd_data[127:64], 64'h0);
      check($sformatf("post_sweep_alt_r%0d", i), alt_rd_data[63:0], 64'h0);
      check($sformatf("post_sweep_alt_r%0d", i + 1), alt_rd_data[127:64], 64'h0);
    end

    // Reset asserted at sweep cycle 10.
    drive(1'b1, 5'd20, 64'h2020, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) drive(1'b0, 5'd0, 64'h0, 5'd20, 5'd20);
      @(negedge clk);
    end
    check("mid_sweep_rd_reg20", rd_data[63:0], 64'h2020);
    check("mid_sweep_busy", {63'h0, busy}, 64'h1);
    #2 reset = 1'b0;
    wr_en = 1'b1;
    #1;
    check("async_rst_busy", {63'h0, busy}, 64'h0);
    check("async_rst_state", {63'h0, dbg_state}, 64'h0);
    check("async_rst_rd0", rd_data[63:0], 64'h0);
    check("async_rst_rd1", rd_data[127:64], 64'h0);
    check("async_rst_wr_drop", {63'h0, wr_drop}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd20, 5'd20);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("no_resume_busy%0d", c), {63'h0, busy}, 64'h0);
    end
    check("rst_cleared_reg20", rd_data[63:0], 64'h0);
    drive(1'b1, 5'd3, 64'h3333, 5'd3, 5'd20);
    #1 check("post_rst_wr_drop", {63'h0, wr_drop}, 64'h0);
    @(negedge clk);
    drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd3);
    @(negedge clk);
    check("post_rst_reg3_p0", rd_data[63:0], 64'h3333);
    check("post_rst_reg3_p1", rd_data[127:64], 64'h3333);

    // clear_req held high re-enters after exactly one idle cycle.
    clear_req = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("held_sweep_len", 64'(cyc), 64'd32);
    check("held_gap_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    check("held_reenter_busy", {63'h0, busy}, 64'h1);
    clear_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("held_second_len", 64'(cyc), 64'd32);
    check("held_reg3_cleared", rd_data[63:0], 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
